// File: rtl/ifetch_mem_responder_pkg.sv
// Shared types and constants for the instruction-fetch memory responder.
// Byte counts are little-endian lane indices into the assembled word.
package ifetch_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  localparam int INSN_BYTES = 4;
  localparam int RVC_BYTES  = 2;
  localparam int CNT_W      = 3;
  localparam logic [1:0] RVC_OPC_MASK = 2'b11;

  // A halfword is compressed unless both opcode low bits are set
  function automatic logic is_rvc(input logic [1:0] opc);
    return (opc & RVC_OPC_MASK) != RVC_OPC_MASK;
  endfunction

endpackage

// File: rtl/ifetch_byte_assembler.sv
// Collects returned RAM bytes into four little-endian lanes, detects a
// compressed instruction from byte 0 and presents the assembled word.
module ifetch_byte_assembler
  import ifetch_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic [7:0]       din,
  input  logic             show,
  output logic [CNT_W-1:0] need,
  output logic             last_capture,
  output logic [31:0]      data
);

  logic [7:0]       lane_reg [INSN_BYTES];
  logic [CNT_W-1:0] cap_cnt_reg;
  logic [31:0]      data_reg;
  logic [31:0]      assembled;
  logic             rvc;

  genvar gi;
  generate
    for (gi = 0; gi < INSN_BYTES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (capture && !clear && cap_cnt_reg == CNT_W'(gi)) begin
          lane_reg[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cap_cnt_reg <= '0;
    end else if (capture) begin
      cap_cnt_reg <= cap_cnt_reg + CNT_W'(1);
    end
  end

  // Lane 0 only means something once it has been captured for this request
  assign rvc          = (cap_cnt_reg != '0) && is_rvc(lane_reg[0][1:0]);
  assign need         = rvc ? CNT_W'(RVC_BYTES) : CNT_W'(INSN_BYTES);
  assign last_capture = capture && !clear && ((cap_cnt_reg + CNT_W'(1)) == need);

  always_comb begin
    assembled = {lane_reg[3], lane_reg[2], lane_reg[1], lane_reg[0]};
    if (rvc) begin
      assembled = {16'h0000, lane_reg[1], lane_reg[0]};
    end
  end

  // The output only changes on a delivered response; aborted requests leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
    end else if (show) begin
      data_reg <= assembled;
    end
  end

  assign data = show ? assembled : data_reg;

endmodule

// File: rtl/ifetch_mem_responder.sv
// Memory-side responder for instruction fetch: issues byte reads to the shared
// RAM under arbiter grant and returns one assembled instruction per request.
module ifetch_mem_responder
  import ifetch_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  asking,
  input  logic [31:0]           addr,
  output logic [31:0]           data,
  output logic                  data_ready,
  output logic                  busy,
  input  logic                  mem_grant,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_a,
  input  logic [7:0]            mem_din
);

  state_t           state_reg, state_next;
  logic [31:0]      base_reg;
  logic [CNT_W-1:0] issue_cnt_reg;
  logic             rd_pending_reg;
  logic             accept;
  logic [CNT_W-1:0] need;
  logic             last_capture;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    mem_rd     = 1'b0;
    data_ready = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        data_ready = (state_reg == DONE) && !flush;
        accept     = asking && !flush;
        state_next = accept ? FETCH : IDLE;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_rd = mem_grant && (issue_cnt_reg < need);
        if (last_capture) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Full 32-bit add before truncation so fetches at the top of RAM wrap to 0
  assign mem_a = mem_rd ? ADDR_WIDTH'(base_reg + 32'(issue_cnt_reg)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      issue_cnt_reg  <= '0;
      rd_pending_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rd_pending_reg <= mem_rd && !flush;
      if (accept) begin
        base_reg      <= addr;
        issue_cnt_reg <= '0;
      end else if (mem_rd) begin
        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
      end
    end
  end

  ifetch_byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept || flush),
    .capture      (rd_pending_reg),
    .din          (mem_din),
    .show         (data_ready),
    .need         (need),
    .last_capture (last_capture),
    .data         (data)
  );

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Scoreboard bench for ifetch_mem_responder: a byte RAM model answers reads one
// cycle later, a monitor logs reads and responses, each scenario checks its own.
module tb_ifetch_mem_responder;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst, flush, asking, mem_grant;
  logic [31:0]   addr;
  logic [31:0]   data;
  logic          data_ready, busy, mem_rd;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_din;

  typedef struct { logic [AW-1:0] a; int c; } rd_t;
  typedef struct { logic [31:0] d; int c; } rsp_t;

  rd_t  rd_q[$], exp_rd[$];
  rsp_t rsp_q[$], exp_rsp[$];
  logic [7:0] ram [0:(1<<AW)-1];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int c0;

  ifetch_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .asking(asking), .addr(addr),
    .data(data), .data_ready(data_ready), .busy(busy), .mem_grant(mem_grant),
    .mem_rd(mem_rd), .mem_a(mem_a), .mem_din(mem_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_din <= ram[mem_a];

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) rd_q.push_back('{mem_a, cyc});
      if (data_ready) rsp_q.push_back('{data, cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    rd_q.delete(); rsp_q.delete(); exp_rd.delete(); exp_rsp.delete();
    c0 = cyc;
  endtask

  task automatic push_reads(input logic [31:0] base, input int n, input int first);
    for (int i = 0; i < n; i++) exp_rd.push_back('{AW'(base + 32'(i)), c0 + first + i});
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; asking = 1'b0; mem_grant = 1'b1; addr = '0;
    repeat (3) tick();
    n_checks++; if (data !== 32'h0) $display("FAIL rst_data got %h want 00000000", data); else n_pass++;
    n_checks++; if (data_ready !== 1'b0) $display("FAIL rst_data_ready got %b want 0", data_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (mem_rd !== 1'b0 || mem_a !== '0) $display("FAIL rst_mem got rd=%b a=%h want rd=0 a=0", mem_rd, mem_a); else n_pass++;
    rst = 1'b0;
    tick();
    start_test();
    // reset mid-fetch, together with flush and asking, must win
    for (int k = 0; k < 10; k++) begin
      asking = (k == 0 || k == 2); addr = 32'h100;
      rst = (k == 2); flush = (k == 2);
      if (k == 3) begin
        n_checks++; if (busy !== 1'b0 || mem_rd !== 1'b0) $display("FAIL rst_mid got busy=%b rd=%b want 0 0", busy, mem_rd); else n_pass++;
      end
      tick();
    end
    asking = 1'b0; rst = 1'b0; flush = 1'b0;
    n_checks++; if (rsp_q.size() != 0) $display("FAIL rst_mid_rsp got %0d responses want 0", rsp_q.size()); else n_pass++;
    n_checks++; if (data !== 32'h0) $display("FAIL rst_mid_data got %h want 00000000", data); else n_pass++;
    $display("reset: done");
  endtask

  task automatic test_basic32();
    rd_t er, gr; rsp_t es, gs;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    start_test();
    push_reads(32'h100, 4, 1); exp_rsp.push_back('{32'h00000513, c0 + 6});
    for (int k = 0; k < 10; k++) begin
      asking = (k == 0); addr = 32'h100;
      if (k == 6) begin
        @(negedge clk);
        n_checks++; if (data_ready !== 1'b1 || busy !== 1'b0) $display("FAIL basic_pulse got dr=%b busy=%b want 1 0", data_ready, busy); else n_pass++;
      end
      tick();
    end
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); n_checks++;
      if (rd_q.size() == 0) $display("FAIL basic_rd got none want a=%h c=+%0d", er.a, er.c - c0);
      else begin gr = rd_q.pop_front(); if (gr.a !== er.a || gr.c != er.c) $display("FAIL basic_rd got a=%h c=+%0d want a=%h c=+%0d", gr.a, gr.c - c0, er.a, er.c - c0); else n_pass++; end
    end
    while (exp_rsp.size() > 0) begin
      es = exp_rsp.pop_front(); n_checks++;
      if (rsp_q.size() == 0) $display("FAIL basic_rsp got none want d=%h c=+%0d", es.d, es.c - c0);
      else begin gs = rsp_q.pop_front(); if (gs.d !== es.d || gs.c != es.c) $display("FAIL basic_rsp got d=%h c=+%0d want d=%h c=+%0d", gs.d, gs.c - c0, es.d, es.c - c0); else begin n_pass++; $display("basic32: rsp %h at +%0d", gs.d, gs.c - c0); end end
    end
    n_checks++; if (rd_q.size() + rsp_q.size() != 0) $display("FAIL basic_extra got %0d want 0", rd_q.size() + rsp_q.size()); else n_pass++;
  endtask

  task automatic test_rvc();
    rd_t er, gr; rsp_t es, gs;
    ram[32'h102] = 8'h82; ram[32'h103] = 8'h80;
    start_test();
    push_reads(32'h102, 2, 1); exp_rsp.push_back('{32'h00008082, c0 + 4});
    for (int k = 0; k < 9; k++) begin
      asking = (k == 0); addr = 32'h102;
      tick();
    end
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); n_checks++;
      if (rd_q.size() == 0) $display("FAIL rvc_rd got none want a=%h c=+%0d", er.a, er.c - c0);
      else begin gr = rd_q.pop_front(); if (gr.a !== er.a || gr.c != er.c) $display("FAIL rvc_rd got a=%h c=+%0d want a=%h c=+%0d", gr.a, gr.c - c0, er.a, er.c - c0); else n_pass++; end
    end
    while (exp_rsp.size() > 0) begin
      es = exp_rsp.pop_front(); n_checks++;
      if (rsp_q.size() == 0) $display("FAIL rvc_rsp got none want d=%h c=+%0d", es.d, es.c - c0);
      else begin gs = rsp_q.pop_front(); if (gs.d !== es.d || gs.c != es.c) $display("FAIL rvc_rsp got d=%h c=+%0d want d=%h c=+%0d", gs.d, gs.c - c0, es.d, es.c - c0); else begin n_pass++; $display("rvc: rsp %h at +%0d", gs.d, gs.c - c0); end end
    end
    n_checks++; if (rd_q.size() + rsp_q.size() != 0) $display("FAIL rvc_extra got %0d want 0", rd_q.size() + rsp_q.size()); else n_pass++;
    ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
  endtask

  task automatic test_grant_stall();
    rd_t er, gr; rsp_t es, gs;
    start_test();
    exp_rd.push_back('{AW'(32'h100), c0 + 1});
    for (int i = 1; i < 4; i++) exp_rd.push_back('{AW'(32'h100 + 32'(i)), c0 + 3 + i});
    exp_rsp.push_back('{32'h00000513, c0 + 8});
    for (int k = 0; k < 12; k++) begin
      asking = (k == 0); addr = 32'h100;
      mem_grant = !(k == 2 || k == 3);
      tick();
    end
    mem_grant = 1'b1;
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); n_checks++;
      if (rd_q.size() == 0) $display("FAIL stall_rd got none want a=%h c=+%0d", er.a, er.c - c0);
      else begin gr = rd_q.pop_front(); if (gr.a !== er.a || gr.c != er.c) $display("FAIL stall_rd got a=%h c=+%0d want a=%h c=+%0d", gr.a, gr.c - c0, er.a, er.c - c0); else n_pass++; end
    end
    while (exp_rsp.size() > 0) begin
      es = exp_rsp.pop_front(); n_checks++;
      if (rsp_q.size() == 0) $display("FAIL stall_rsp got none want d=%h c=+%0d", es.d, es.c - c0);
      else begin gs = rsp_q.pop_front(); if (gs.d !== es.d || gs.c != es.c) $display("FAIL stall_rsp got d=%h c=+%0d want d=%h c=+%0d", gs.d, gs.c - c0, es.d, es.c - c0); else begin n_pass++; $display("stall: rsp %h at +%0d", gs.d, gs.c - c0); end end
    end
    n_checks++; if (rd_q.size() + rsp_q.size() != 0) $display("FAIL stall_extra got %0d want 0", rd_q.size() + rsp_q.size()); else n_pass++;
  endtask

  task automatic test_flush();
    rd_t er, gr; rsp_t es, gs;
    ram[32'h200] = 8'hb7; ram[32'h201] = 8'h12; ram[32'h202] = 8'h00; ram[32'h203] = 8'h00;
    start_test();
    push_reads(32'h100, 3, 1); push_reads(32'h200, 4, 6);
    exp_rsp.push_back('{32'h000012b7, c0 + 11});
    for (int k = 0; k < 14; k++) begin
      asking = (k == 0 || k == 5); addr = (k == 5) ? 32'h200 : 32'h100;
      flush = (k == 3);
      if (k == 4) begin
        @(negedge clk);
        n_checks++; if (data !== 32'h00000513 || busy !== 1'b0) $display("FAIL flush_hold got d=%h busy=%b want 00000513 0", data, busy); else n_pass++;
      end
      tick();
    end
    asking = 1'b0; flush = 1'b0;
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); n_checks++;
      if (rd_q.size() == 0) $display("FAIL flush_rd got none want a=%h c=+%0d", er.a, er.c - c0);
      else begin gr = rd_q.pop_front(); if (gr.a !== er.a || gr.c != er.c) $display("FAIL flush_rd got a=%h c=+%0d want a=%h c=+%0d", gr.a, gr.c - c0, er.a, er.c - c0); else n_pass++; end
    end
    while (exp_rsp.size() > 0) begin
      es = exp_rsp.pop_front(); n_checks++;
      if (rsp_q.size() == 0) $display("FAIL flush_rsp got none want d=%h c=+%0d", es.d, es.c - c0);
      else begin gs = rsp_q.pop_front(); if (gs.d !== es.d || gs.c != es.c) $display("FAIL flush_rsp got d=%h c=+%0d want d=%h c=+%0d", gs.d, gs.c - c0, es.d, es.c - c0); else begin n_pass++; $display("flush: rsp %h at +%0d", gs.d, gs.c - c0); end end
    end
    n_checks++; if (rd_q.size() + rsp_q.size() != 0) $display("FAIL flush_extra got %0d want 0", rd_q.size() + rsp_q.size()); else n_pass++;
  endtask

  task automatic test_flush_done();
    start_test();
    for (int k = 0; k < 10; k++) begin
      asking = (k == 0 || k == 6); addr = (k == 6) ? 32'h200 : 32'h100;
      flush = (k == 6);
      if (k == 6) begin
        @(negedge clk);
        n_checks++; if (data_ready !== 1'b0 || data !== 32'h000012b7) $display("FAIL fdone_pulse got dr=%b d=%h want 0 000012b7", data_ready, data); else n_pass++;
      end
      if (k == 7) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL fdone_drop got busy=%b want 0", busy); else n_pass++;
      end
      tick();
    end
    asking = 1'b0; flush = 1'b0;
    n_checks++; if (rd_q.size() != 4 || rsp_q.size() != 0) $display("FAIL fdone_counts got rd=%0d rsp=%0d want 4 0", rd_q.size(), rsp_q.size()); else n_pass++;
    n_checks++; if (data !== 32'h000012b7) $display("FAIL fdone_data got %h want 000012b7", data); else n_pass++;
    $display("flush_done: no response, data %h", data);
  endtask

  task automatic test_wrap();
    rd_t er, gr; rsp_t es, gs;
    logic [AW-1:0] want_a [4];
    want_a[0] = 17'h1FFFE; want_a[1] = 17'h1FFFF; want_a[2] = 17'h00000; want_a[3] = 17'h00001;
    ram[17'h1FFFE] = 8'h93; ram[17'h1FFFF] = 8'h00; ram[17'h00000] = 8'h10; ram[17'h00001] = 8'h00;
    start_test();
    for (int i = 0; i < 4; i++) exp_rd.push_back('{want_a[i], c0 + 1 + i});
    exp_rsp.push_back('{32'h00100093, c0 + 6});
    for (int k = 0; k < 10; k++) begin
      asking = (k == 0); addr = 32'h0001FFFE;
      tick();
    end
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); n_checks++;
      if (rd_q.size() == 0) $display("FAIL wrap_rd got none want a=%h c=+%0d", er.a, er.c - c0);
      else begin gr = rd_q.pop_front(); if (gr.a !== er.a || gr.c != er.c) $display("FAIL wrap_rd got a=%h c=+%0d want a=%h c=+%0d", gr.a, gr.c - c0, er.a, er.c - c0); else n_pass++; end
    end
    while (exp_rsp.size() > 0) begin
      es = exp_rsp.pop_front(); n_checks++;
      if (rsp_q.size() == 0) $display("FAIL wrap_rsp got none want d=%h c=+%0d", es.d, es.c - c0);
      else begin gs = rsp_q.pop_front(); if (gs.d !== es.d || gs.c != es.c) $display("FAIL wrap_rsp got d=%h c=+%0d want d=%h c=+%0d", gs.d, gs.c - c0, es.d, es.c - c0); else begin n_pass++; $display("wrap: rsp %h at +%0d", gs.d, gs.c - c0); end end
    end
    n_checks++; if (rd_q.size() + rsp_q.size() != 0) $display("FAIL wrap_extra got %0d want 0", rd_q.size() + rsp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    rd_t er, gr; rsp_t es, gs;
    ram[32'h104] = 8'h41; ram[32'h105] = 8'h11;
    start_test();
    push_reads(32'h100, 4, 1); push_reads(32'h104, 2, 7);
    exp_rsp.push_back('{32'h00000513, c0 + 6});
    exp_rsp.push_back('{32'h00001141, c0 + 10});
    for (int k = 0; k < 14; k++) begin
      asking = (k == 0 || k == 2 || k == 3 || k == 6 || k == 8);
      addr = (k == 0) ? 32'h100 : (k == 6) ? 32'h104 : 32'h300;
      tick();
    end
    asking = 1'b0;
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front(); n_checks++;
      if (rd_q.size() == 0) $display("FAIL b2b_rd got none want a=%h c=+%0d", er.a, er.c - c0);
      else begin gr = rd_q.pop_front(); if (gr.a !== er.a || gr.c != er.c) $display("FAIL b2b_rd got a=%h c=+%0d want a=%h c=+%0d", gr.a, gr.c - c0, er.a, er.c - c0); else n_pass++; end
    end
    while (exp_rsp.size() > 0) begin
      es = exp_rsp.pop_front(); n_checks++;
      if (rsp_q.size() == 0) $display("FAIL b2b_rsp got none want d=%h c=+%0d", es.d, es.c - c0);
      else begin gs = rsp_q.pop_front(); if (gs.d !== es.d || gs.c != es.c) $display("FAIL b2b_rsp got d=%h c=+%0d want d=%h c=+%0d", gs.d, gs.c - c0, es.d, es.c - c0); else begin n_pass++; $display("b2b: rsp %h at +%0d", gs.d, gs.c - c0); end end
    end
    n_checks++; if (rd_q.size() + rsp_q.size() != 0) $display("FAIL b2b_extra got %0d want 0", rd_q.size() + rsp_q.size()); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    test_reset();
    test_basic32();
    test_rvc();
    test_grant_stall();
    test_flush();
    test_flush_done();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
